// File: rtl/recirc_pkg.sv
// recirc_pkg: state encoding and shared constants for the recirculator link controller
package recirc_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [31:0] DEF_SYNC_WORD = 32'hBCBCBCBC;
  localparam int ERR_CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SYNC = ST_SYNC,
    ACTIVE = ST_ACTIVE,
    UNUSED = 2'd3
  } state_t;
endpackage

// File: rtl/run_counter.sv
// run_counter: consecutive-event counter; hit flags the increment that reaches thr
module run_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] thr,
  output logic             hit
);
  logic [CNT_W-1:0] cnt;
  assign hit = inc && (cnt + CNT_W'(1) == thr);
  // clearing on hit keeps the count from ever exceeding the threshold
  always_ff @(posedge clk_2f)
    cnt <= (!reset || clr || hit) ? '0 : inc ? cnt + CNT_W'(1) : cnt;
endmodule

// File: rtl/recirc_link_ctrl.sv
// recirc_link_ctrl: sync/loss sequencer driving the recirculator active qualifier
// RECIRC_ERR_CNT_EN enables the saturating link_lost event counter on err_cnt.
module recirc_link_ctrl
  import recirc_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int          SYNC_CNT  = 4,
  parameter int          LOSS_CNT  = 3,
  parameter int          CNT_W     = 4
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic                 valid,
  input  logic [31:0]          data_in,
  output logic                 active,
  output logic [1:0]           state,
  output logic                 link_lost,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  state_t st, st_n;
  logic sync_inc, loss_inc, sync_hit, loss_hit, lost_n;
  assign sync_inc = st == SYNC && cfg_enable && valid && data_in == SYNC_WORD;
  assign loss_inc = st == ACTIVE && cfg_enable && !valid;
  run_counter #(.CNT_W(CNT_W)) u_sync_run (
    .clk_2f(clk_2f), .reset(reset), .inc(sync_inc), .clr(!sync_inc),
    .thr(CNT_W'(SYNC_CNT)), .hit(sync_hit)
  );
  run_counter #(.CNT_W(CNT_W)) u_loss_run (
    .clk_2f(clk_2f), .reset(reset), .inc(loss_inc), .clr(!loss_inc),
    .thr(CNT_W'(LOSS_CNT)), .hit(loss_hit)
  );
  // disable outranks both completions; the counters see inc=0 in that case too
  always_comb begin
    st_n = st;
    lost_n = 1'b0;
    case (st)
      IDLE:    st_n = cfg_enable ? SYNC : IDLE;
      SYNC:    st_n = !cfg_enable ? IDLE : sync_hit ? ACTIVE : SYNC;
      ACTIVE: begin
        st_n = !cfg_enable ? IDLE : loss_hit ? SYNC : ACTIVE;
        lost_n = cfg_enable && loss_hit;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_2f) begin
    st <= !reset ? IDLE : st_n;
    active <= reset && st_n == ACTIVE;
    link_lost <= reset && lost_n;
  end
  assign state = st;
`ifdef RECIRC_ERR_CNT_EN
  always_ff @(posedge clk_2f)
    err_cnt <= !reset ? '0 : (lost_n && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_recirc_link_ctrl.sv
// tb_recirc_link_ctrl: vector table, directed corner sequences and randomized model check
module tb_recirc_link_ctrl;
  localparam logic [31:0] SW = 32'hBCBCBCBC;
  localparam int SC = 4;
  localparam int LC = 3;
`ifdef RECIRC_ERR_CNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  logic clk_2f = 1'b0, reset = 1'b0, cfg_enable = 1'b0, valid = 1'b0;
  logic [31:0] data_in = '0;
  logic active, link_lost;
  logic [1:0] state;
  logic [7:0] err_cnt;
  int vecs = 0, errs = 0;
  int m_st = 0, m_sr = 0, m_lr = 0, m_err = 0;
  bit m_lost = 0;
  recirc_link_ctrl #(.SYNC_WORD(SW), .SYNC_CNT(SC), .LOSS_CNT(LC), .CNT_W(4)) dut (
    .clk_2f(clk_2f), .reset(reset), .cfg_enable(cfg_enable), .valid(valid),
    .data_in(data_in), .active(active), .state(state), .link_lost(link_lost),
    .err_cnt(err_cnt)
  );
  always #5 clk_2f = ~clk_2f;
  typedef struct {
    bit rst_n, en, v;
    logic [31:0] d;
    logic [1:0] st;
    bit act, lost;
  } vec_t;
  vec_t tbl[$];
  task automatic apply(input bit r, input bit en, input bit v, input logic [31:0] d);
    @(negedge clk_2f);
    reset = r; cfg_enable = en; valid = v; data_in = d;
    @(posedge clk_2f);
    #1;
    m_lost = 0;
    if (!r) begin
      m_st = 0; m_sr = 0; m_lr = 0; m_err = 0;
    end else if (m_st == 0) begin
      if (en) m_st = 1;
    end else if (!en) begin
      m_st = 0; m_sr = 0; m_lr = 0;
    end else if (m_st == 1) begin
      m_sr = (v && d == SW) ? m_sr + 1 : 0;
      if (m_sr == SC) begin m_st = 2; m_sr = 0; end
    end else begin
      m_lr = v ? 0 : m_lr + 1;
      if (m_lr == LC) begin
        m_st = 1; m_lr = 0; m_lost = 1;
        if (m_err < 255) m_err++;
      end
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model(input string name);
    int exp_err;
    exp_err = ERR_ON ? m_err : 0;
    vecs++;
    if (state != 2'(m_st) || active != (m_st == 2) || link_lost != m_lost || err_cnt != 8'(exp_err)) begin
      errs++;
      $display("FAIL %s: got st=%0d act=%0b lost=%0b err=%0d expected st=%0d act=%0b lost=%0b err=%0d at %0t",
               name, state, active, link_lost, err_cnt, m_st, m_st == 2, m_lost, exp_err, $time);
    end
  endtask
  task automatic syncs(input int n);
    for (int i = 0; i < n; i++) apply(1, 1, 1, SW);
  endtask
  initial begin
    tbl.push_back('{0, 0, 0, 32'h0, 2'd0, 0, 0});
    tbl.push_back('{0, 1, 1, SW, 2'd0, 0, 0});
    tbl.push_back('{1, 1, 0, 32'h0, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd2, 1, 0});
    tbl.push_back('{1, 0, 1, SW, 2'd0, 0, 0});
    tbl.push_back('{1, 1, 0, 32'h0, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, 32'h12345678, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd1, 0, 0});
    tbl.push_back('{1, 1, 1, SW, 2'd2, 1, 0});
    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].en, tbl[i].v, tbl[i].d);
      vecs++;
      if (state != tbl[i].st || active != tbl[i].act || link_lost != tbl[i].lost || err_cnt != 8'd0) begin
        errs++;
        $display("FAIL table[%0d]: got st=%0d act=%0b lost=%0b err=%0d expected st=%0d act=%0b lost=%0b err=0",
                 i, state, active, link_lost, err_cnt, tbl[i].st, tbl[i].act, tbl[i].lost);
      end
    end
    // loss with an interrupted run: only the third consecutive idle cycle counts
    apply(1, 1, 0, 0); apply(1, 1, 0, 0); apply(1, 1, 1, 32'h5);
    apply(1, 1, 0, 0); apply(1, 1, 0, 0);
    chk("no_early_loss", {state, active, link_lost}, {2'd2, 1'b1, 1'b0});
    apply(1, 1, 0, 0);
    chk("loss_state", state, 1);
    chk("loss_active", active, 0);
    chk("loss_pulse", link_lost, 1);
    chk("loss_err", err_cnt, ERR_ON ? 1 : 0);
    apply(1, 1, 0, 0);
    chk("pulse_one_cycle", link_lost, 0);
    // disable coinciding with the third idle cycle
    syncs(SC);
    chk("reactivate", active, 1);
    apply(1, 1, 0, 0); apply(1, 1, 0, 0); apply(1, 0, 0, 0);
    chk("dis_state", state, 0);
    chk("dis_active", active, 0);
    chk("dis_no_pulse", link_lost, 0);
    chk("dis_err_kept", err_cnt, ERR_ON ? 1 : 0);
    // reset pulse while active
    apply(1, 1, 0, 0); syncs(SC);
    chk("pre_reset_active", active, 1);
    apply(0, 1, 1, SW);
    chk("reset_all_zero", {state, active, link_lost, err_cnt}, 0);
    apply(1, 1, 1, SW);
    chk("post_reset_sync", state, 1);
    syncs(SC - 1);
    chk("post_reset_3_words", {state, active}, {2'd1, 1'b0});
    syncs(1);
    chk("post_reset_active", {state, active}, {2'd2, 1'b1});
    // err_cnt saturation over 260 loss events
    for (int k = 0; k < 260; k++) begin
      for (int j = 0; j < LC; j++) apply(1, 1, 0, 0);
      syncs(SC);
    end
    chk("err_saturate", err_cnt, ERR_ON ? 255 : 0);
    check_model("model_sync");
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 99) != 0, $urandom_range(0, 29) != 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8 ? SW : $urandom);
      check_model("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
